// File: rtl/flux_sched_pkg.sv
// Shared types and helpers for the round-robin flux scheduler.
package flux_sched_pkg;

  localparam int STAT_W = 16;

  typedef enum logic {
    FREE = 1'b0,
    LOCK = 1'b1
  } sched_state_t;

  function automatic int tag_w(input int flux);
    return (flux > 1) ? $clog2(flux) : 1;
  endfunction

endpackage

// File: rtl/flux_rr_pick.sv
// Rotating priority encoder: first set request at or after i_start, wrapping modulo FLUX.
module flux_rr_pick
  import flux_sched_pkg::*;
#(
  parameter int FLUX      = 2,
  parameter int TAG_WIDTH = tag_w(FLUX)
) (
  input  logic [FLUX-1:0]      i_req,
  input  logic [TAG_WIDTH-1:0] i_start,
  output logic                 o_valid,
  output logic [TAG_WIDTH-1:0] o_index
);

  // Pick the request with the smallest rotational distance from the start index.
  always_comb begin
    int   v_start;
    int   v_dist;
    int   v_best;
    logic v_take;
    o_valid = 1'b0;
    o_index = {TAG_WIDTH{1'b0}};
    v_start = int'(i_start);
    v_dist  = 0;
    v_best  = FLUX;
    v_take  = 1'b0;
    for (int i = 0; i < FLUX; i++) begin
      v_dist  = (i >= v_start) ? (i - v_start) : (i + FLUX - v_start);
      v_take  = i_req[i] && (v_dist < v_best);
      v_best  = v_take ? v_dist : v_best;
      o_index = v_take ? TAG_WIDTH'(i) : o_index;
      o_valid = o_valid | v_take;
    end
  end

endmodule

// File: rtl/flux_rr_scheduler.sv
// Round-robin flux scheduler with bounded burst locking for shared-datapath actors.
// Optional statistics outputs are built when FLUX_SCHED_STATS_EN is defined.
module flux_rr_scheduler
  import flux_sched_pkg::*;
#(
  parameter int FLUX      = 2,
  parameter int N_IN      = 2,
  parameter int MAX_BURST = 4,
  parameter int TAG_WIDTH = tag_w(FLUX)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN*FLUX-1:0]   in_empty,
  input  logic                   out_full,
  output logic                   fire,
  output logic [TAG_WIDTH-1:0]   tag,
  output logic [FLUX-1:0]        read_vec,
  output logic                   locked
`ifdef FLUX_SCHED_STATS_EN
  ,
  output logic [FLUX*STAT_W-1:0] stat_fire_cnt,
  output logic [FLUX-1:0]        stat_starve
`endif
);

  localparam int                   CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [TAG_WIDTH-1:0] LAST_TAG  = TAG_WIDTH'(FLUX - 1);
  localparam logic [CNT_W-1:0]     BURST_MAX = CNT_W'(MAX_BURST);

  if (FLUX < 2) begin : g_bad_flux
    $error("flux_rr_scheduler: FLUX must be at least 2");
  end
  if (MAX_BURST < 1) begin : g_bad_burst
    $error("flux_rr_scheduler: MAX_BURST must be at least 1");
  end

  function automatic logic [TAG_WIDTH-1:0] next_tag(input logic [TAG_WIDTH-1:0] t);
    return (t == LAST_TAG) ? {TAG_WIDTH{1'b0}} : (t + TAG_WIDTH'(1));
  endfunction

  sched_state_t           r_state;
  logic [TAG_WIDTH-1:0]   r_lock_tag;
  logic [CNT_W-1:0]       r_burst_cnt;
  logic [TAG_WIDTH-1:0]   r_rr_ptr;

  logic [FLUX-1:0]        w_eligible;
  logic [TAG_WIDTH-1:0]   w_start;
  logic                   w_pick_valid;
  logic [TAG_WIDTH-1:0]   w_pick_idx;
  logic                   w_lock_hit;
  logic [CNT_W-1:0]       w_cnt_inc;

  // A flux is eligible when the output has room and every input port holds data for it.
  always_comb begin
    w_eligible = {FLUX{1'b0}};
    for (int i = 0; i < FLUX; i++) begin
      w_eligible[i] = ~out_full;
      for (int k = 0; k < N_IN; k++) begin
        w_eligible[i] = w_eligible[i] & ~in_empty[k*FLUX + i];
      end
    end
  end

  // A lock that ran dry resumes the scan just past the locked flux.
  assign w_start    = (r_state == LOCK) ? next_tag(r_lock_tag) : r_rr_ptr;
  assign w_lock_hit = (r_state == LOCK) && w_eligible[r_lock_tag];
  assign w_cnt_inc  = r_burst_cnt + CNT_W'(1);
  assign locked     = (r_state == LOCK);

  flux_rr_pick #(
    .FLUX      (FLUX),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_pick (
    .i_req   (w_eligible),
    .i_start (w_start),
    .o_valid (w_pick_valid),
    .o_index (w_pick_idx)
  );

  // Same-cycle fire decision: held lock first, otherwise the rotating winner.
  always_comb begin
    fire     = 1'b0;
    tag      = {TAG_WIDTH{1'b0}};
    read_vec = {FLUX{1'b0}};
    if (!rst && w_lock_hit) begin
      fire = 1'b1;
      tag  = r_lock_tag;
    end else if (!rst && w_pick_valid) begin
      fire = 1'b1;
      tag  = w_pick_idx;
    end else begin
      fire = 1'b0;
      tag  = {TAG_WIDTH{1'b0}};
    end
    for (int i = 0; i < FLUX; i++) begin
      read_vec[i] = fire && (tag == TAG_WIDTH'(i));
    end
  end

  // Scheduler FSM; a full output freezes every piece of state, including a held lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FREE;
      r_lock_tag  <= {TAG_WIDTH{1'b0}};
      r_burst_cnt <= {CNT_W{1'b0}};
      r_rr_ptr    <= {TAG_WIDTH{1'b0}};
    end else if (!out_full) begin
      case (r_state)
        FREE: begin
          if (w_pick_valid) begin
            if (MAX_BURST == 1) begin
              r_rr_ptr <= next_tag(w_pick_idx);
            end else begin
              r_state     <= LOCK;
              r_lock_tag  <= w_pick_idx;
              r_burst_cnt <= CNT_W'(1);
            end
          end
        end
        LOCK: begin
          if (w_lock_hit) begin
            if (w_cnt_inc == BURST_MAX) begin
              r_state     <= FREE;
              r_rr_ptr    <= next_tag(r_lock_tag);
              r_burst_cnt <= {CNT_W{1'b0}};
            end else begin
              r_burst_cnt <= w_cnt_inc;
            end
          end else if (w_pick_valid) begin
            r_lock_tag  <= w_pick_idx;
            r_burst_cnt <= CNT_W'(1);
          end else begin
            r_state     <= FREE;
            r_rr_ptr    <= next_tag(r_lock_tag);
            r_burst_cnt <= {CNT_W{1'b0}};
          end
        end
        default: begin
          r_state     <= FREE;
          r_burst_cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

`ifdef FLUX_SCHED_STATS_EN
  localparam int               STARVE_LIM = 2 * FLUX * MAX_BURST;
  localparam int               RUN_W      = $clog2(STARVE_LIM + 1);
  localparam logic [RUN_W-1:0] RUN_LAST   = RUN_W'(STARVE_LIM - 1);
  localparam logic [RUN_W-1:0] RUN_SAT    = RUN_W'(STARVE_LIM);

  logic [FLUX-1:0][STAT_W-1:0] r_fire_cnt;
  logic [FLUX-1:0][RUN_W-1:0]  r_wait_run;
  logic [FLUX-1:0]             r_starve;

  // Per-flux saturating fire counters and sticky eligible-but-unserved detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fire_cnt <= '0;
      r_wait_run <= '0;
      r_starve   <= {FLUX{1'b0}};
    end else begin
      for (int i = 0; i < FLUX; i++) begin
        if (read_vec[i] && (r_fire_cnt[i] != {STAT_W{1'b1}})) begin
          r_fire_cnt[i] <= r_fire_cnt[i] + STAT_W'(1);
        end
        if (w_eligible[i] && !read_vec[i]) begin
          if (r_wait_run[i] == RUN_LAST) begin
            r_starve[i] <= 1'b1;
          end
          if (r_wait_run[i] != RUN_SAT) begin
            r_wait_run[i] <= r_wait_run[i] + RUN_W'(1);
          end
        end else begin
          r_wait_run[i] <= {RUN_W{1'b0}};
        end
      end
    end
  end

  assign stat_fire_cnt = r_fire_cnt;
  assign stat_starve   = r_starve;
`endif

endmodule

// File: tb/tb_flux_rr_scheduler.sv
// Directed self-checking bench for flux_rr_scheduler (FLUX=2, N_IN=2, MAX_BURST=4).
module tb_flux_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_empty = 4'b0000;
  logic       out_full = 1'b0;
  logic       fire;
  logic [0:0] tag;
  logic [1:0] read_vec;
  logic       locked;
`ifdef FLUX_SCHED_STATS_EN
  logic [31:0] stat_fire_cnt;
  logic [1:0]  stat_starve;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flux_rr_scheduler #(
    .FLUX      (2),
    .N_IN      (2),
    .MAX_BURST (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_empty (in_empty),
    .out_full (out_full),
    .fire     (fire),
    .tag      (tag),
    .read_vec (read_vec),
    .locked   (locked)
`ifdef FLUX_SCHED_STATS_EN
    ,
    .stat_fire_cnt (stat_fire_cnt),
    .stat_starve   (stat_starve)
`endif
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Bit layout of in_empty: {port1 flux1, port1 flux0, port0 flux1, port0 flux0}.
  task automatic cyc(input string name, input logic r, input logic [3:0] emp, input logic full,
                     input logic e_fire, input logic e_tag, input logic [1:0] e_rv,
                     input logic e_lock);
    @(negedge clk);
    rst      = r;
    in_empty = emp;
    out_full = full;
    #1;
    chk({name, ".fire"}, {31'd0, fire}, {31'd0, e_fire});
    chk({name, ".tag"}, {31'd0, tag}, {31'd0, e_tag});
    chk({name, ".read_vec"}, {30'd0, read_vec}, {30'd0, e_rv});
    chk({name, ".locked"}, {31'd0, locked}, {31'd0, e_lock});
  endtask

  initial begin
    // Reset held with every flux ready: outputs forced quiet.
    @(negedge clk);
    #1;
    chk("rst0.fire", {31'd0, fire}, 32'd0);
    chk("rst0.read_vec", {30'd0, read_vec}, 32'd0);
    cyc("rst1", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

    // All ready: bursts of four, alternating.
    cyc("rr1",  1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    cyc("rr2",  1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1);
    cyc("rr3",  1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1);
    cyc("rr4",  1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1);
    cyc("rr5",  1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0);
    cyc("rr6",  1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1);
    cyc("rr7",  1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1);
    cyc("rr8",  1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1);
    cyc("rr9",  1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    cyc("rr10", 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1);

    // Only flux 0 ready (port0 flux1 empty): lock ends at 4, flux 0 re-won.
    cyc("solo1", 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1);
    cyc("solo2", 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1);
    cyc("solo3", 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    cyc("solo4", 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1);
    cyc("solo5", 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1);
    cyc("solo6", 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1);

    // Lock on flux 1 at count 2, then flux 1 runs dry: same-cycle switch to flux 0.
    cyc("sw1", 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0);
    cyc("sw2", 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1);
    cyc("sw3", 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1);
    cyc("sw4", 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1);
    cyc("sw5", 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1);
    cyc("sw6", 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1);
    cyc("sw7", 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0);

    // Output full for 3 cycles at count 2: burst resumes at 3 on flux 1.
    cyc("full0", 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1);
    cyc("full1", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    cyc("full2", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    cyc("full3", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    cyc("full4", 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1);
    cyc("full5", 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1);
    cyc("full6", 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);

    // Port 1 flux 0 empty: flux 0 is never chosen.
    cyc("p1e1", 1'b0, 4'b0100, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1);
    cyc("p1e2", 1'b0, 4'b0100, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1);
    cyc("p1e3", 1'b0, 4'b0100, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1);
    cyc("p1e4", 1'b0, 4'b0100, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1);
    cyc("p1e5", 1'b0, 4'b0100, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0);

    // Lock on flux 1 drains with nothing ready: release, pointer moves to flux 0.
    cyc("dry1", 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    cyc("dry2", 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    cyc("dry3", 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    cyc("dry4", 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    cyc("dry5", 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0);

    // Reset while locked on flux 1: quiet during reset, flux 0 wins afterwards.
    cyc("mrst1", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    cyc("mrst2", 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
`ifdef FLUX_SCHED_STATS_EN
    chk("stat_cnt_after_rst", stat_fire_cnt, 32'd0);
    chk("stat_starve_after_rst", {30'd0, stat_starve}, 32'd0);
    cyc("mrst3", 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1);
    chk("stat_cnt_one_fire", stat_fire_cnt, 32'h0000_0001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flux_rr_scheduler.md
Name: flux_rr_scheduler

Overview:
- Flux-selection controller for multi-flux dataflow actors (adders, multipliers and similar) that share one datapath between FLUX tagged data streams.
- Replaces the fixed lowest-index-first flux choice with round-robin arbitration and bounded burst locking, so no flux starves.
- Sits between an actor's read/write FIFO status and its datapath:
  - drives the flux tag, the fire strobe and the per-flux read strobes;
  - the actor keeps only the arithmetic.

Parameters:
- FLUX, 2, number of tagged data streams; must be >= 2 (elaboration error otherwise).
- N_IN, 2, number of actor input ports; all must be non-empty for a flux to fire.
- MAX_BURST, 4, maximum consecutive firings granted to one flux before rotation; >= 1.
- TAG_WIDTH, $clog2(FLUX), derived width of the tag; not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_empty  in  N_IN*FLUX  empty flags; bit k*FLUX+i = input port k, flux i.
- out_full  in  1  output FIFO full.
- fire  out  1  datapath fires this cycle; drives output write and input reads.
- tag  out  TAG_WIDTH  flux being fired; 0 when fire=0.
- read_vec  out  FLUX  one-hot read strobe for the fired flux, shared by all N_IN ports; all-zero when fire=0.
- locked  out  1  registered; a burst lock is held.

Behaviour:
- eligible[i] = out_full==0 and in_empty[k*FLUX+i]==0 for every k.
- fire, tag and read_vec are combinational from eligible and registered state (zero-latency, same-cycle FIFO pop, FWFT FIFOs). State updates on the clk edge after a fire.
- Registered state:
  - lock_v: 1 bit.
  - lock_tag: TAG_WIDTH.
  - burst_cnt: $clog2(MAX_BURST+1) bits.
  - rr_ptr: TAG_WIDTH.
- Reset: lock_v=0, lock_tag=0, burst_cnt=0, rr_ptr=0. While rst=1, fire=0, tag=0, read_vec=0 regardless of inputs.
- State FREE (lock_v=0):
  - Winner = first eligible index scanning rr_ptr, rr_ptr+1, ... mod FLUX.
  - No eligible flux: fire=0, no state change.
  - Winner found: fire=1, tag=winner.
    - MAX_BURST==1: stay FREE, rr_ptr=winner+1 mod FLUX.
    - Otherwise: go to LOCK with lock_tag=winner, burst_cnt=1.
- State LOCK (lock_v=1):
  - eligible[lock_tag]=1: fire lock_tag, burst_cnt+1. If the new count equals MAX_BURST, go to FREE with rr_ptr=lock_tag+1 mod FLUX and burst_cnt=0.
  - eligible[lock_tag]=0 and out_full==0 (lock flux ran dry): release in the same cycle. Arbitrate as FREE with scan starting at lock_tag+1, so the cycle is work-conserving. The next state follows the FREE rules; if nothing is eligible, go to FREE with rr_ptr=lock_tag+1.
- out_full=1 in any state: fire=0, and lock_v, lock_tag, burst_cnt and rr_ptr all hold. A full output never breaks a lock.
- rr_ptr wraps FLUX-1 -> 0. For non-power-of-2 FLUX, tags >= FLUX are never produced.
- Reset asserted mid-burst: lock is dropped and rr_ptr returns to 0 on the next edge.
- Exactly one bit of read_vec is set when fire=1, and read_vec[tag]==fire always.

Optional Feature:
- Macro FLUX_SCHED_STATS_EN.
- Defined:
  - Adds output stat_fire_cnt, width FLUX*16: per-flux 16-bit counters, saturating at 16'hFFFF, incremented on each fire of that flux, cleared by rst.
  - Adds output stat_starve, width FLUX: bit i is set when flux i has been eligible but unfired for 2*FLUX*MAX_BURST consecutive cycles; sticky until rst.
- Undefined: neither port exists and no counter logic is synthesized. Core behaviour is identical in both builds.

Decomposition:
- Package flux_sched_pkg holds:
  - function tag_w(FLUX);
  - typedef enum {FREE, LOCK} sched_state_t;
  - localparam STAT_W=16.
- Sub-module flux_rr_pick:
  - Combinational rotating priority encoder.
  - Inputs: request vector, start index.
  - Outputs: valid, index.
  - Instantiated once; the LOCK-release path reuses it with start=lock_tag+1.

Test Plan:
- Reset, then FLUX=2, N_IN=2, MAX_BURST=4, all inputs non-empty, out_full=0 for 10 cycles -> tags 0,0,0,0,1,1,1,1,0,0; read_vec follows as 01,01,01,01,10,...
- Flux 0 only eligible, 6 cycles -> 6 fires with tag=0. Lock releases after 4; flux 0 is then re-won since it is the only one eligible.
- In LOCK on tag 1 with burst_cnt=2, flux 1 empties while flux 0 is eligible -> same cycle fire=1, tag=0; locked stays 1 with new lock_tag=0, burst_cnt=1.
- out_full=1 for 3 cycles mid-burst (burst_cnt=2) -> fire=0 throughout; after out_full falls the burst resumes at count 3 on the same tag.
- in_empty[2+0]=1 (port 1 flux 0 empty), port 0 flux 0 non-empty, flux 1 fully non-empty -> flux 0 never fires, tag=1.
- rst pulsed while locked on tag 1 -> fire=0 during rst; afterwards, with both fluxes eligible, the first fire is tag 0. With FLUX_SCHED_STATS_EN defined, stat_fire_cnt reads 0 after reset.
